// File: rtl/alu_pkg.sv
// Shared opcode values, flag bit positions and sequencer state encoding
// for the single-issue ALU sequencer.
package alu_pkg;

   localparam logic [3:0] OP_JMP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_LSL = 4'h3;
   localparam logic [3:0] OP_LSR = 4'h4;
   localparam logic [3:0] OP_AND = 4'h5;
   localparam logic [3:0] OP_OR  = 4'h6;
   localparam logic [3:0] OP_XOR = 4'h7;
   localparam logic [3:0] OP_LD  = 4'h8;
   localparam logic [3:0] OP_ST  = 4'h9;
   localparam logic [3:0] OP_MOV = 4'hA;
   localparam logic [3:0] OP_BEQ = 4'hB;
   localparam logic [3:0] OP_BNE = 4'hC;
   localparam logic [3:0] OP_BLT = 4'hD;
   localparam logic [3:0] OP_BGT = 4'hE;
   localparam logic [3:0] OP_CMP = 4'hF;

   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MEM  = 2'd2,
      ST_WB   = 2'd3
   } state_t;

   function automatic logic is_branch(input logic [3:0] op);
      return (op == OP_JMP) || ((op >= OP_BEQ) && (op <= OP_BGT));
   endfunction

   function automatic logic is_alu_wb(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

endpackage

// File: rtl/alu_branch_cond.sv
// Branch resolution: decides taken/not-taken from the opcode and the
// committed N, Z, V flags. Purely combinational.
module alu_branch_cond
   import alu_pkg::*;
(
   input  logic [3:0] i_op,
   input  logic       i_n,
   input  logic       i_z,
   input  logic       i_v,
   output logic       o_taken
);

   always_comb begin
      o_taken = 1'b0;
      case (i_op)
         OP_JMP:  o_taken = 1'b1;
         OP_BEQ:  o_taken = i_z;
         OP_BNE:  o_taken = !i_z;
         OP_BLT:  o_taken = i_n ^ i_v;
         OP_BGT:  o_taken = !i_z && (i_n == i_v);
         default: o_taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Single-issue sequencer: decode handshake -> ALU / memory port / writeback,
// owns the NZCV register and resolves branches. All outputs are registered.
module alu_seq_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int RD_W        = 3,
   parameter int MEM_TIMEOUT = 64
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [RD_W-1:0]   instr_rd,
   input  logic [DATA_W-1:0] instr_a,
   input  logic [DATA_W-1:0] instr_b,
   output logic [3:0]        alu_func,
   output logic [DATA_W-1:0] alu_op0,
   output logic [DATA_W-1:0] alu_op1,
   output logic              alu_flag_en,
   output logic [3:0]        alu_flag_in,
   input  logic [DATA_W-1:0] alu_q,
   input  logic [3:0]        alu_flag_out,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              br_valid,
   output logic              br_taken,
   output logic [DATA_W-1:0] br_target,
   output logic [3:0]        flags,
   output logic              mem_err
);

   localparam int CNT_W  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam int LAST_I = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LAST_I);

   state_t             r_state;
   logic [3:0]         r_op;
   logic [RD_W-1:0]    r_rd;
   logic [DATA_W-1:0]  r_a;
   logic [DATA_W-1:0]  r_b;
   logic [3:0]         r_flags;
   logic [CNT_W-1:0]   r_wait;
   logic               r_instr_ready;
   logic [3:0]         r_alu_func;
   logic [DATA_W-1:0]  r_alu_op0;
   logic [DATA_W-1:0]  r_alu_op1;
   logic               r_alu_flag_en;
   logic               r_wb_valid;
   logic [RD_W-1:0]    r_wb_rd;
   logic [DATA_W-1:0]  r_wb_data;
   logic               r_mem_req;
   logic               r_mem_we;
   logic [DATA_W-1:0]  r_mem_addr;
   logic [DATA_W-1:0]  r_mem_wdata;
   logic               r_br_valid;
   logic               r_br_taken;
   logic               r_mem_err;
   logic               w_taken;
   logic               w_timeout;

   // Resolved at accept time against the committed flags; a CMP always
   // commits before the next instruction can be accepted.
   alu_branch_cond u_branch_cond (
      .i_op    (instr_op),
      .i_n     (r_flags[FLG_N]),
      .i_z     (r_flags[FLG_Z]),
      .i_v     (r_flags[FLG_V]),
      .o_taken (w_taken)
   );

   assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == LAST_WAIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_op          <= '0;
         r_rd          <= '0;
         r_a           <= '0;
         r_b           <= '0;
         r_flags       <= '0;
         r_wait        <= '0;
         r_instr_ready <= 1'b1;
         r_alu_func    <= '0;
         r_alu_op0     <= '0;
         r_alu_op1     <= '0;
         r_alu_flag_en <= 1'b0;
         r_wb_valid    <= 1'b0;
         r_wb_rd       <= '0;
         r_wb_data     <= '0;
         r_mem_req     <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_br_valid    <= 1'b0;
         r_br_taken    <= 1'b0;
         r_mem_err     <= 1'b0;
      end else begin
         r_alu_func    <= '0;
         r_alu_op0     <= '0;
         r_alu_op1     <= '0;
         r_alu_flag_en <= 1'b0;
         r_br_valid    <= 1'b0;
         r_br_taken    <= 1'b0;
         r_mem_err     <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  r_op          <= instr_op;
                  r_rd          <= instr_rd;
                  r_a           <= instr_a;
                  r_b           <= instr_b;
                  r_alu_func    <= instr_op;
                  r_alu_op0     <= instr_a;
                  r_alu_op1     <= instr_b;
                  r_alu_flag_en <= is_alu_wb(instr_op) || (instr_op == OP_CMP);
                  r_br_valid    <= is_branch(instr_op);
                  r_br_taken    <= is_branch(instr_op) && w_taken;
                  r_instr_ready <= 1'b0;
                  r_state       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (r_op)
                  OP_ADD, OP_SUB, OP_LSL, OP_LSR, OP_AND, OP_OR, OP_XOR: begin
                     r_flags    <= alu_flag_out;
                     r_wb_data  <= alu_q;
                     r_wb_rd    <= r_rd;
                     r_wb_valid <= 1'b1;
                     r_state    <= ST_WB;
                  end
                  OP_MOV: begin
                     r_wb_data  <= r_b;
                     r_wb_rd    <= r_rd;
                     r_wb_valid <= 1'b1;
                     r_state    <= ST_WB;
                  end
                  OP_CMP: begin
                     r_flags       <= alu_flag_out;
                     r_instr_ready <= 1'b1;
                     r_state       <= ST_IDLE;
                  end
                  OP_LD, OP_ST: begin
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= (r_op == OP_ST);
                     r_mem_addr  <= r_b;
                     r_mem_wdata <= r_a;
                     r_wait      <= '0;
                     r_state     <= ST_MEM;
                  end
                  default: begin
                     r_instr_ready <= 1'b1;
                     r_state       <= ST_IDLE;
                  end
               endcase
            end
            ST_MEM: begin
               // An ack in the last waiting cycle takes priority over the timeout.
               if (mem_ack || w_timeout) begin
                  r_mem_req   <= 1'b0;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  if (mem_ack && (r_op == OP_LD)) begin
                     r_wb_data  <= mem_rdata;
                     r_wb_rd    <= r_rd;
                     r_wb_valid <= 1'b1;
                     r_state    <= ST_WB;
                  end else begin
                     r_mem_err     <= !mem_ack;
                     r_instr_ready <= 1'b1;
                     r_state       <= ST_IDLE;
                  end
               end else begin
                  r_wait <= r_wait + CNT_W'(1);
               end
            end
            ST_WB: begin
               if (wb_ready) begin
                  r_wb_valid    <= 1'b0;
                  r_instr_ready <= 1'b1;
                  r_state       <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign instr_ready = r_instr_ready;
   assign alu_func    = r_alu_func;
   assign alu_op0     = r_alu_op0;
   assign alu_op1     = r_alu_op1;
   assign alu_flag_en = r_alu_flag_en;
   assign alu_flag_in = r_flags;
   assign wb_valid    = r_wb_valid;
   assign wb_rd       = r_wb_rd;
   assign wb_data     = r_wb_data;
   assign mem_req     = r_mem_req;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign br_valid    = r_br_valid;
   assign br_taken    = r_br_taken;
   assign br_target   = r_a;
   assign flags       = r_flags;
   assign mem_err     = r_mem_err;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: transaction-level expectations per cycle, a small
// behavioural ALU, directed scenarios and a randomized instruction stream.
module tb_alu_seq_ctrl;
   import alu_pkg::*;

   localparam int DW = 16;
   localparam int RW = 3;
   localparam int T  = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic instr_valid = 1'b0, instr_ready;
   logic [3:0] instr_op = '0;
   logic [RW-1:0] instr_rd = '0;
   logic [DW-1:0] instr_a = '0, instr_b = '0;
   logic [3:0] alu_func, alu_flag_in, alu_flag_out, flags;
   logic [DW-1:0] alu_op0, alu_op1, alu_q, wb_data, mem_addr, mem_wdata, br_target;
   logic [DW-1:0] mem_rdata = '0;
   logic alu_flag_en, wb_valid, mem_req, mem_we, br_valid, br_taken, mem_err;
   logic wb_ready = 1'b0, mem_ack = 1'b0;
   logic [RW-1:0] wb_rd;

   always #5 clk = ~clk;

   alu_seq_ctrl #(.DATA_W(DW), .RD_W(RW), .MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_rd(instr_rd), .instr_a(instr_a), .instr_b(instr_b),
      .alu_func(alu_func), .alu_op0(alu_op0), .alu_op1(alu_op1),
      .alu_flag_en(alu_flag_en), .alu_flag_in(alu_flag_in),
      .alu_q(alu_q), .alu_flag_out(alu_flag_out),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
      .flags(flags), .mem_err(mem_err)
   );

   // Behavioural 16-bit ALU: returns {N,Z,C,V, result}. C on SUB/CMP means no borrow.
   function automatic logic [19:0] alu_fn(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      logic [15:0] r;
      logic c, v;
      r = '0; c = 1'b0; v = 1'b0;
      case (f)
         4'h1: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]); end
         4'h2, 4'hF: begin r = a - b; c = (a >= b); v = (a[15] != b[15]) && (r[15] != a[15]); end
         4'h3: r = a << b[3:0];
         4'h4: r = a >> b[3:0];
         4'h5: r = a & b;
         4'h6: r = a | b;
         4'h7: r = a ^ b;
         default: r = '0;
      endcase
      return {r[15], (r == 16'h0), c, v, r};
   endfunction

   assign {alu_flag_out, alu_q} = alu_fn(alu_func, alu_op0, alu_op1);

   function automatic logic br_model(input logic [3:0] op, input logic [3:0] f);
      logic n, z, v;
      n = f[3]; z = f[2]; v = f[0];
      if (op == 4'h0) return 1'b1;
      if (op == 4'hB) return z;
      if (op == 4'hC) return !z;
      if (op == 4'hD) return n != v;
      if (op == 4'hE) return !z && (n == v);
      return 1'b0;
   endfunction

   int n_tests = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle, set by the driver.
   logic exp_ready, exp_flag_en, exp_wb_valid, exp_mem_req, exp_we, exp_br_valid, exp_taken, exp_err;
   logic [3:0] exp_func, exp_flags;
   logic [DW-1:0] exp_op0, exp_op1, exp_wb_data, exp_addr, exp_wdata, exp_target;
   logic [RW-1:0] exp_rd;
   bit chk_en = 1'b0;
   bit err_pending = 1'b0;
   bit hold_valid = 1'b0;
   logic [3:0] m_flags = '0;
   logic seen_taken;
   logic [DW-1:0] seen_target, seen_wb;
   int seen_req;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("instr_ready", 32'(instr_ready), 32'(exp_ready));
         chk("alu_func", 32'(alu_func), 32'(exp_func));
         chk("alu_op0", 32'(alu_op0), 32'(exp_op0));
         chk("alu_op1", 32'(alu_op1), 32'(exp_op1));
         chk("alu_flag_en", 32'(alu_flag_en), 32'(exp_flag_en));
         chk("alu_flag_in", 32'(alu_flag_in), 32'(exp_flags));
         chk("flags", 32'(flags), 32'(exp_flags));
         chk("wb_valid", 32'(wb_valid), 32'(exp_wb_valid));
         if (exp_wb_valid) begin
            chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
            chk("wb_data", 32'(wb_data), 32'(exp_wb_data));
         end
         chk("mem_req", 32'(mem_req), 32'(exp_mem_req));
         if (exp_mem_req) begin
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
         end
         chk("br_valid", 32'(br_valid), 32'(exp_br_valid));
         if (exp_br_valid) begin
            chk("br_taken", 32'(br_taken), 32'(exp_taken));
            chk("br_target", 32'(br_target), 32'(exp_target));
         end
         chk("mem_err", 32'(mem_err), 32'(exp_err));
      end
   end

   // Advance one cycle; inputs the DUT must ignore are randomized.
   task automatic next_cycle(input bit idle);
      @(posedge clk);
      #1;
      exp_ready = idle; exp_func = '0; exp_op0 = '0; exp_op1 = '0; exp_flag_en = 1'b0;
      exp_wb_valid = 1'b0; exp_rd = '0; exp_wb_data = '0;
      exp_mem_req = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0;
      exp_br_valid = 1'b0; exp_taken = 1'b0; exp_target = '0;
      exp_err = err_pending; err_pending = 1'b0;
      exp_flags = m_flags;
      instr_valid = idle ? 1'b0 : (hold_valid ? 1'b1 : 1'($urandom));
      instr_op = 4'($urandom); instr_rd = RW'($urandom);
      instr_a = 16'($urandom); instr_b = 16'($urandom);
      mem_ack = 1'($urandom); mem_rdata = 16'($urandom); wb_ready = 1'($urandom);
   endtask

   task automatic wb_phase(input logic [RW-1:0] rd, input logic [DW-1:0] d, input int dly);
      for (int w = 0; w <= dly; w++) begin
         next_cycle(1'b0);
         exp_wb_valid = 1'b1; exp_rd = rd; exp_wb_data = d;
         if (w == 0) seen_wb = wb_data;
         wb_ready = (w == dly);
      end
   endtask

   // ack_dly: MEM cycle (1-based) carrying mem_ack, 0 = never.
   task automatic run_instr(input logic [3:0] op, input logic [RW-1:0] rd, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input int ack_dly, input logic [DW-1:0] rdata,
                            input int wb_dly);
      logic [19:0] r;
      int k;
      bit acked;
      next_cycle(1'b1);
      instr_valid = 1'b1; instr_op = op; instr_rd = rd; instr_a = a; instr_b = b;
      next_cycle(1'b0);
      exp_func = op; exp_op0 = a; exp_op1 = b;
      r = alu_fn(op, a, b);
      exp_flag_en = ((op >= 4'h1) && (op <= 4'h7)) || (op == 4'hF);
      if ((op == 4'h0) || ((op >= 4'hB) && (op <= 4'hE))) begin
         exp_br_valid = 1'b1; exp_taken = br_model(op, m_flags); exp_target = a;
         seen_taken = br_taken; seen_target = br_target;
      end
      if ((op >= 4'h1) && (op <= 4'h7)) begin
         m_flags = r[19:16];
         wb_phase(rd, r[15:0], wb_dly);
      end else if (op == 4'hA) begin
         wb_phase(rd, b, wb_dly);
      end else if (op == 4'hF) begin
         m_flags = r[19:16];
      end else if ((op == 4'h8) || (op == 4'h9)) begin
         k = 0; acked = 1'b0; seen_req = 0;
         while (!acked && (k < T)) begin
            next_cycle(1'b0);
            exp_mem_req = 1'b1; exp_we = (op == 4'h9); exp_addr = b; exp_wdata = a;
            seen_req += int'(mem_req);
            mem_ack = (ack_dly != 0) && (k == ack_dly - 1);
            if (mem_ack) begin mem_rdata = rdata; acked = 1'b1; end
            k++;
         end
         if (!acked) err_pending = 1'b1;
         else if (op == 4'h8) wb_phase(rd, rdata, wb_dly);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready"}, 32'(instr_ready), 32'd1);
      chk({tag, "_alu"}, {12'h0, alu_func, alu_op0}, 32'd0);
      chk({tag, "_alu_op1"}, {15'h0, alu_flag_en, alu_op1}, 32'd0);
      chk({tag, "_wb"}, {7'h0, wb_valid, wb_rd, wb_data, 2'b0, mem_err, mem_req}, 32'd0);
      chk({tag, "_mem"}, {mem_addr, mem_wdata}, 32'd0);
      chk({tag, "_br"}, {9'h0, mem_we, br_valid, br_taken, alu_flag_in, br_target}, 32'd0);
      chk({tag, "_flags"}, 32'(flags), 32'd0);
   endtask

   function automatic logic [DW-1:0] rnd16();
      return ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
   endfunction

   initial begin
      #2 rst_n = 1'b0;
      #1 check_reset("reset");
      @(posedge clk); @(posedge clk);
      #3 rst_n = 1'b1;
      next_cycle(1'b1);
      chk_en = 1'b1;
      next_cycle(1'b1);

      run_instr(OP_ADD, 3'd1, 16'h0001, 16'h0001, 0, 16'h0, 0);
      chk("lit_add_wb", 32'(seen_wb), 32'h0002);
      chk("lit_add_flags", 32'(flags), 32'h0);

      run_instr(OP_CMP, 3'd0, 16'h0005, 16'h000A, 0, 16'h0, 0);
      run_instr(OP_BLT, 3'd0, 16'h1234, 16'h0000, 0, 16'h0, 0);
      chk("lit_cmp_flags", 32'(flags), 32'h8);
      chk("lit_blt_taken", 32'(seen_taken), 32'd1);
      chk("lit_blt_target", 32'(seen_target), 32'h1234);
      run_instr(OP_BGT, 3'd0, 16'h4321, 16'h0000, 0, 16'h0, 0);
      chk("lit_bgt_taken", 32'(seen_taken), 32'd0);

      run_instr(OP_LD, 3'd5, 16'h0000, 16'h0040, 3, 16'hBEEF, 2);
      chk("lit_ld_req_cycles", 32'(seen_req), 32'd3);
      chk("lit_ld_wb", 32'(seen_wb), 32'hBEEF);

      run_instr(OP_ST, 3'd0, 16'h5555, 16'h0080, 0, 16'h0, 0);
      chk("lit_st_req_cycles", 32'(seen_req), 32'd4);
      next_cycle(1'b1);
      chk("lit_st_err", 32'(mem_err), 32'd1);
      chk("lit_st_req_drop", 32'(mem_req), 32'd0);
      chk("lit_st_flags", 32'(flags), 32'h8);

      run_instr(OP_LD, 3'd2, 16'h0000, 16'h0010, T, 16'hCAFE, 0);

      hold_valid = 1'b1;
      run_instr(OP_SUB, 3'd4, 16'h0009, 16'h0003, 0, 16'h0, 2);
      run_instr(OP_MOV, 3'd6, 16'h0000, 16'hA5A5, 0, 16'h0, 1);
      hold_valid = 1'b0;

      // Reset while a load waits in MEM.
      chk_en = 1'b0;
      next_cycle(1'b1);
      instr_valid = 1'b1; instr_op = OP_LD; instr_b = 16'h0040;
      next_cycle(1'b0);
      next_cycle(1'b0);
      mem_ack = 1'b0; instr_valid = 1'b0;
      chk("rst_mem_req_before", 32'(mem_req), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset("rst_mem");
      @(posedge clk);
      #3 rst_n = 1'b1;
      m_flags = '0; err_pending = 1'b0;

      // Reset while a result waits in WB with nonzero flags.
      next_cycle(1'b1);
      instr_valid = 1'b1; instr_op = OP_ADD; instr_rd = 3'd3; instr_a = 16'h8000; instr_b = 16'h8000;
      next_cycle(1'b0);
      next_cycle(1'b0);
      wb_ready = 1'b0; instr_valid = 1'b0;
      chk("rst_wb_valid_before", 32'(wb_valid), 32'd1);
      chk("rst_wb_flags_before", 32'(flags), 32'h7);
      #2 rst_n = 1'b0;
      #1 check_reset("rst_wb");
      @(posedge clk);
      #3 rst_n = 1'b1;
      m_flags = '0;
      next_cycle(1'b1);
      chk_en = 1'b1;

      run_instr(OP_BEQ, 3'd0, 16'h0BEE, 16'h0, 0, 16'h0, 0);
      chk("lit_post_rst_beq", 32'(seen_taken), 32'd0);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) next_cycle(1'b1);
         run_instr(4'($urandom), 3'($urandom), rnd16(), rnd16(),
                   $urandom_range(0, T), 16'($urandom), $urandom_range(0, 3));
      end
      next_cycle(1'b1);
      next_cycle(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
